// File: rtl/fifo_pop_stream_if.sv
// Bus bundle for fifo_pop_stream: the FIFO read port (fifo_empty/fifo_dout/
// fifo_rd_en), the downstream valid/ready stream (m_valid/m_ready/m_data)
// and the accepted-transfer counter (pop_count).
// master = the adapter; slave = the FIFO plus consumer environment.
interface fifo_pop_stream_if #(
  parameter int DATA_W = 16
);
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_rd_en;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [15:0]       pop_count;

  modport master (
    input  fifo_empty, fifo_dout, m_ready,
    output fifo_rd_en, m_valid, m_data, pop_count
  );

  modport slave (
    output fifo_empty, fifo_dout, m_ready,
    input  fifo_rd_en, m_valid, m_data, pop_count
  );
endinterface

// File: rtl/fifo_pop_stream.sv
// fifo_pop_stream: drains a synchronous FIFO with one-cycle read latency
// into a valid/ready stream through a 2-entry skid buffer (head/tail).
// Reads are only issued when a landing slot is guaranteed, counting the
// word already in flight and the slot freed by a same-cycle pop, so the
// stream sustains one word per cycle and never drops or duplicates data.
// Optional feature macro: FIFO_POP_STATS_EN enables the 16-bit wrapping
// pop_count; without it pop_count is tied to zero.
// Note: fifo_rd_en depends combinationally on m_ready (pop credit).
module fifo_pop_stream #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  fifo_pop_stream_if.master bus
);

  logic [1:0]        occ;
  logic              inflight;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] tail;

  logic [1:0]        occ_n;
  logic [DATA_W-1:0] head_n;
  logic [DATA_W-1:0] tail_n;

  logic              pop;
  logic [2:0]        credit;

  assign bus.m_valid = (occ != 2'd0);
  assign bus.m_data  = head;
  assign pop         = bus.m_valid & bus.m_ready;

  // Slots committed after this edge: held words plus the in-flight word,
  // minus the head leaving now. A read is legal only if that leaves room.
  assign credit         = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign bus.fifo_rd_en = !rst && !bus.fifo_empty && (credit < 3'd2);

  // Skid-buffer next state: land the in-flight word, retire the head,
  // keeping FIFO order when both happen together.
  always_comb begin
    occ_n  = occ;
    head_n = head;
    tail_n = tail;
    case ({pop, inflight})
      2'b01: begin
        if (occ == 2'd0) begin
          head_n = bus.fifo_dout;
          occ_n  = 2'd1;
        end else begin
          tail_n = bus.fifo_dout;
          occ_n  = 2'd2;
        end
      end
      2'b10: begin
        head_n = tail;
        occ_n  = occ - 2'd1;
      end
      2'b11: begin
        if (occ == 2'd1) begin
          head_n = bus.fifo_dout;
        end else begin
          head_n = tail;
          tail_n = bus.fifo_dout;
        end
      end
      default: ;
    endcase
  end

  // Buffer and read-tracking registers; reset discards everything held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
    end else begin
      occ      <= occ_n;
      inflight <= bus.fifo_rd_en;
      head     <= head_n;
      tail     <= tail_n;
    end
  end

`ifdef FIFO_POP_STATS_EN
  logic [15:0] pop_cnt;

  // Accepted-transfer counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pop_cnt <= 16'h0000;
    end else if (pop) begin
      pop_cnt <= pop_cnt + 16'h0001;
    end
  end

  assign bus.pop_count = pop_cnt;
`else
  assign bus.pop_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fifo_pop_stream.sv
module tb_fifo_pop_stream;
  localparam int DATA_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fifo_pop_stream_if #(.DATA_W(DATA_W)) bus ();

  fifo_pop_stream #(.DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [0:255];
  logic [7:0]        wr_ptr = 8'd0;
  logic [7:0]        rd_ptr = 8'd0;

  assign bus.fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      bus.fifo_dout <= mem[rd_ptr];
      rd_ptr        <= rd_ptr + 8'd1;
    end
  end

  int                checks = 0;
  int                errors = 0;
  logic [DATA_W-1:0] exp_q [$];
  logic [15:0]       pops = 16'h0000;

  function automatic logic [15:0] exp_pc();
`ifdef FIFO_POP_STATS_EN
    return pops;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [DATA_W-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr      = wr_ptr + 8'd1;
    exp_q.push_back(w);
  endtask

  task automatic drain(input string tag, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      if (exp_q.size() == 0 && bus.m_valid == 1'b0) done = 1'b1;
      else cyc(1);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, done, 1'b1);
    end
  endtask

  task automatic monitor();
    logic [DATA_W-1:0] w;
    forever begin
      @(negedge clk);
      if (rst) begin
        pops = 16'h0000;
      end else begin
        checks++;
        if ((bus.fifo_rd_en & bus.fifo_empty) !== 1'b0) begin
          errors++;
          $error("FAIL no_underflow: observed %h expected %h", bus.fifo_rd_en & bus.fifo_empty, 1'b0);
        end
        checks++;
        if (dut.occ > 2'd2) begin
          errors++;
          $error("FAIL occ_le_2: observed %h expected <= 2", dut.occ);
        end
        if (bus.m_valid && bus.m_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL output_expected: observed %h with empty queue", bus.m_data);
          end else begin
            w = exp_q.pop_front();
            checks++;
            if (bus.m_data !== w) begin
              errors++;
              $error("FAIL stream_data: observed %h expected %h", bus.m_data, w);
            end
            pops = pops + 16'h0001;
          end
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int written;
    int rdcnt;
    int vcnt;
    logic [DATA_W-1:0] w;

    fork
      monitor();
    join_none

    bus.m_ready = 1'b0;
    #2;
    checks++;
    if (bus.m_valid !== 1'b0) begin errors++; $error("FAIL rst_m_valid: observed %h expected %h", bus.m_valid, 1'b0); end
    checks++;
    if (bus.m_data !== 16'h0000) begin errors++; $error("FAIL rst_m_data: observed %h expected %h", bus.m_data, 16'h0000); end
    checks++;
    if (bus.fifo_rd_en !== 1'b0) begin errors++; $error("FAIL rst_rd_en: observed %h expected %h", bus.fifo_rd_en, 1'b0); end
    checks++;
    if (bus.pop_count !== 16'h0000) begin errors++; $error("FAIL rst_pop_count: observed %h expected %h", bus.pop_count, 16'h0000); end
    cyc(2);
    rst = 1'b0;
    cyc(1);

    // Streaming at full rate
    bus.m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(16'(i));
    #0;
    checks++;
    if (bus.fifo_rd_en !== 1'b1) begin errors++; $error("FAIL lat_rd_en_N: observed %h expected %h", bus.fifo_rd_en, 1'b1); end
    cyc(1);
    checks++;
    if (bus.m_valid !== 1'b0) begin errors++; $error("FAIL lat_valid_N1: observed %h expected %h", bus.m_valid, 1'b0); end
    cyc(1);
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (bus.m_valid !== 1'b1) begin errors++; $error("FAIL burst_valid: observed %h expected %h", bus.m_valid, 1'b1); end
      checks++;
      if (bus.m_data !== 16'(i)) begin errors++; $error("FAIL burst_data: observed %h expected %h", bus.m_data, 16'(i)); end
      cyc(1);
    end
    checks++;
    if (bus.m_valid !== 1'b0) begin errors++; $error("FAIL burst_end_valid: observed %h expected %h", bus.m_valid, 1'b0); end
    checks++;
    if (bus.pop_count !== exp_pc()) begin errors++; $error("FAIL burst_pop_count: observed %h expected %h", bus.pop_count, exp_pc()); end

    // Backpressure stall
    bus.m_ready = 1'b0;
    push(16'hA5A5);
    push(16'h5A5A);
    push(16'h0F0F);
    cyc(3);
    checks++;
    if (dut.occ !== 2'd2) begin errors++; $error("FAIL stall_occ: observed %h expected %h", dut.occ, 2'd2); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.fifo_rd_en !== 1'b0) begin errors++; $error("FAIL stall_rd_en: observed %h expected %h", bus.fifo_rd_en, 1'b0); end
      checks++;
      if (bus.m_valid !== 1'b1) begin errors++; $error("FAIL stall_valid: observed %h expected %h", bus.m_valid, 1'b1); end
      checks++;
      if (bus.m_data !== 16'hA5A5) begin errors++; $error("FAIL stall_data: observed %h expected %h", bus.m_data, 16'hA5A5); end
      cyc(1);
    end
    bus.m_ready = 1'b1;
    #1;
    checks++;
    if (bus.fifo_rd_en !== 1'b1) begin errors++; $error("FAIL credit_rd_en: observed %h expected %h", bus.fifo_rd_en, 1'b1); end
    checks++;
    if (bus.m_data !== 16'hA5A5) begin errors++; $error("FAIL credit_head: observed %h expected %h", bus.m_data, 16'hA5A5); end
    drain("stall_drain", 50);

    // Random traffic against random backpressure
    written = 0;
    while (written < 50) begin
      bus.m_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) != 0) begin
        w = 16'($random);
        push(w);
        written++;
      end
      cyc(1);
    end
    bus.m_ready = 1'b1;
    drain("random_drain", 300);

    // Single word: one read, one transfer, then idle
    cyc(2);
    push(16'h1234);
    #0;
    rdcnt = 0;
    vcnt  = 0;
    for (int i = 0; i < 8; i++) begin
      rdcnt += int'(bus.fifo_rd_en);
      vcnt  += int'(bus.m_valid);
      cyc(1);
    end
    checks++;
    if (rdcnt !== 1) begin errors++; $error("FAIL single_rd_pulses: observed %0d expected %0d", rdcnt, 1); end
    checks++;
    if (vcnt !== 1) begin errors++; $error("FAIL single_valid_cycles: observed %0d expected %0d", vcnt, 1); end
    checks++;
    if (bus.m_valid !== 1'b0) begin errors++; $error("FAIL single_idle_valid: observed %h expected %h", bus.m_valid, 1'b0); end
    checks++;
    if (bus.fifo_rd_en !== 1'b0) begin errors++; $error("FAIL single_idle_rd_en: observed %h expected %h", bus.fifo_rd_en, 1'b0); end

    // Asynchronous reset mid-stream with a word in flight
    bus.m_ready = 1'b0;
    push(16'hC001);
    push(16'hC002);
    push(16'hC003);
    push(16'hC004);
    cyc(2);
    checks++;
    if (dut.occ !== 2'd1) begin errors++; $error("FAIL pre_rst_occ: observed %h expected %h", dut.occ, 2'd1); end
    checks++;
    if (dut.inflight !== 1'b1) begin errors++; $error("FAIL pre_rst_inflight: observed %h expected %h", dut.inflight, 1'b1); end
    checks++;
    if (bus.m_valid !== 1'b1) begin errors++; $error("FAIL pre_rst_valid: observed %h expected %h", bus.m_valid, 1'b1); end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.m_valid !== 1'b0) begin errors++; $error("FAIL async_rst_valid: observed %h expected %h", bus.m_valid, 1'b0); end
    checks++;
    if (bus.m_data !== 16'h0000) begin errors++; $error("FAIL async_rst_data: observed %h expected %h", bus.m_data, 16'h0000); end
    checks++;
    if (bus.pop_count !== 16'h0000) begin errors++; $error("FAIL async_rst_pop_count: observed %h expected %h", bus.pop_count, 16'h0000); end
    checks++;
    if (bus.fifo_rd_en !== 1'b0) begin errors++; $error("FAIL async_rst_rd_en: observed %h expected %h", bus.fifo_rd_en, 1'b0); end
    exp_q.delete();
    wr_ptr = rd_ptr;
    cyc(1);
    rst = 1'b0;
    cyc(1);
    checks++;
    if (bus.m_valid !== 1'b0) begin errors++; $error("FAIL post_rst_valid: observed %h expected %h", bus.m_valid, 1'b0); end
    bus.m_ready = 1'b1;
    push(16'hBEE1);
    push(16'hBEE2);
    push(16'hBEE3);
    drain("post_rst_drain", 30);
    checks++;
    if (bus.pop_count !== exp_pc()) begin errors++; $error("FAIL post_rst_pop_count: observed %h expected %h", bus.pop_count, exp_pc()); end

    // Counter wrap
`ifdef FIFO_POP_STATS_EN
    dut.pop_cnt = 16'hFFFE;
    pops        = 16'hFFFE;
`endif
    push(16'h7001);
    push(16'h7002);
    push(16'h7003);
    drain("wrap_drain", 30);
`ifdef FIFO_POP_STATS_EN
    checks++;
    if (bus.pop_count !== 16'h0001) begin errors++; $error("FAIL wrap_pop_count: observed %h expected %h", bus.pop_count, 16'h0001); end
`else
    checks++;
    if (bus.pop_count !== 16'h0000) begin errors++; $error("FAIL nostats_pop_count: observed %h expected %h", bus.pop_count, 16'h0000); end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
